// File: rtl/ritmo_pkg.sv
// Shared types and constants for the rhythm-game score keeper.
package ritmo_pkg;

   typedef enum logic [1:0] {OCIOSO, JOGANDO, FIM} estado_t;

   localparam int unsigned SCORE_W    = 20;
   localparam int unsigned COMBO_W    = 8;
   localparam int unsigned SCORE_MAX  = 999999;
   localparam int unsigned COMBO_STEP = 10;
   localparam int unsigned MULT_MAX   = 4;

endpackage

// File: rtl/detector_de_borda.sv
// Registered rising-edge detector on a lane vector; output is one cycle behind the first
// high sample of each lane.
module detector_de_borda #(
   parameter int unsigned N_LANES = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_LANES-1:0] nivel,
   output logic [N_LANES-1:0] borda
);

   logic [N_LANES-1:0] prev_q;
   logic [N_LANES-1:0] borda_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         borda_q <= '0;
      end else begin
         prev_q  <= nivel;
         borda_q <= nivel & ~prev_q;
      end
   end

   assign borda = borda_q;

endmodule

// File: rtl/contador_de_pontos.sv
// Score/combo keeper: edge-detects per-lane hits and misses and accumulates a saturating
// score scaled by a combo multiplier while the game is running.
module contador_de_pontos #(
   parameter int unsigned N_LANES    = 8,
   parameter int unsigned SCORE_MAX  = ritmo_pkg::SCORE_MAX,
   parameter int unsigned COMBO_STEP = ritmo_pkg::COMBO_STEP,
   parameter int unsigned MULT_MAX   = ritmo_pkg::MULT_MAX
) (
   input  logic                          CLOCK_25,
   input  logic                          rst_n,
   input  logic [N_LANES-1:0]            ponto,
   input  logic [N_LANES-1:0]            erro,
   input  logic                          inicio,
   input  logic                          fim_de_jogo,
   output logic [ritmo_pkg::SCORE_W-1:0] score,
   output logic [ritmo_pkg::COMBO_W-1:0] combo,
   output logic [ritmo_pkg::COMBO_W-1:0] max_combo,
   output logic [2:0]                    multiplicador,
   output logic                          jogando,
   output logic                          novo_ponto
);

   import ritmo_pkg::*;

   localparam int unsigned H_W   = $clog2(N_LANES + 1);
   localparam int unsigned ADD_W = H_W + 3;
   localparam logic [SCORE_W:0] SCORE_MAX_EXT = (SCORE_W + 1)'(SCORE_MAX);

   function automatic logic [H_W-1:0] popcount(input logic [N_LANES-1:0] v);
      logic [H_W-1:0] n;
      n = '0;
      for (int i = 0; i < N_LANES; i++) begin
         n = n + H_W'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [2:0] calc_mult(input logic [COMBO_W-1:0] c);
      int unsigned q;
      q = 32'(c) / COMBO_STEP + 1;
      if (q > MULT_MAX) q = MULT_MAX;
      return 3'(q);
   endfunction

   estado_t state_q, state_d;

   logic [N_LANES-1:0] hit_e, miss_e, hit_v;
   logic [SCORE_W-1:0] score_q, score_d, score_new;
   logic [COMBO_W-1:0] combo_q, combo_d, combo_new;
   logic [COMBO_W-1:0] max_q, max_d;
   logic               novo_q, novo_d;
   logic               cap_ok_q;
   logic [H_W-1:0]     h;
   logic               m;
   logic [2:0]         mult;
   logic [ADD_W-1:0]   add;
   logic [SCORE_W:0]   soma;
   logic [COMBO_W:0]   combo_sum;
   logic               entrada, aplica;

   detector_de_borda #(.N_LANES(N_LANES)) u_borda_ponto (
      .clk   (CLOCK_25),
      .rst_n (rst_n),
      .nivel (ponto),
      .borda (hit_e)
   );

   detector_de_borda #(.N_LANES(N_LANES)) u_borda_erro (
      .clk   (CLOCK_25),
      .rst_n (rst_n),
      .nivel (erro),
      .borda (miss_e)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OCIOSO:  if (inicio) state_d = JOGANDO;
         JOGANDO: if (fim_de_jogo) state_d = FIM;
         FIM:     if (inicio) state_d = JOGANDO;
         default: state_d = OCIOSO;
      endcase
   end

   // A lane with both edges in one cycle is a miss only.
   assign hit_v = hit_e & ~miss_e;
   assign h     = popcount(hit_v);
   assign m     = |miss_e;
   assign mult  = calc_mult(combo_q);

   always_comb begin
      add       = ADD_W'(h) * ADD_W'(mult);
      soma      = (SCORE_W + 1)'(score_q) + (SCORE_W + 1)'(add);
      score_new = (soma > SCORE_MAX_EXT) ? SCORE_MAX_EXT[SCORE_W-1:0] : soma[SCORE_W-1:0];
      combo_sum = (COMBO_W + 1)'(combo_q) + (COMBO_W + 1)'(h);
      if (m) begin
         combo_new = '0;
      end else if (combo_sum[COMBO_W]) begin
         combo_new = '1;
      end else begin
         combo_new = combo_sum[COMBO_W-1:0];
      end
   end

   // Edges captured outside JOGANDO (including the entry cycle) never reach the counters.
   assign entrada = (state_d == JOGANDO) && (state_q != JOGANDO);
   assign aplica  = (state_q == JOGANDO) && cap_ok_q;

   always_comb begin
      score_d = score_q;
      combo_d = combo_q;
      max_d   = max_q;
      novo_d  = 1'b0;
      if (entrada) begin
         score_d = '0;
         combo_d = '0;
         max_d   = '0;
      end else if (aplica) begin
         score_d = score_new;
         combo_d = combo_new;
         max_d   = (combo_new > max_q) ? combo_new : max_q;
         novo_d  = (score_new != score_q);
      end
   end

   always_ff @(posedge CLOCK_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OCIOSO;
         score_q  <= '0;
         combo_q  <= '0;
         max_q    <= '0;
         novo_q   <= 1'b0;
         cap_ok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         combo_q  <= combo_d;
         max_q    <= max_d;
         novo_q   <= novo_d;
         cap_ok_q <= (state_q == JOGANDO);
      end
   end

   assign score         = score_q;
   assign combo         = combo_q;
   assign max_combo     = max_q;
   assign multiplicador = mult;
   assign jogando       = (state_q == JOGANDO);
   assign novo_ponto    = novo_q;

endmodule

// File: tb/tb_contador_de_pontos.sv
// Directed bench for contador_de_pontos: table of single-cycle lane pulses plus hand sequences.
module tb_contador_de_pontos;

   logic        CLOCK_25 = 1'b0;
   logic        rst_n;
   logic [7:0]  ponto, erro;
   logic        inicio, fim_de_jogo;
   logic [19:0] score;
   logic [7:0]  combo, max_combo;
   logic [2:0]  multiplicador;
   logic        jogando, novo_ponto;

   logic [7:0]  s_ponto, s_erro;
   logic        s_inicio, s_fim;
   logic [19:0] s_score;
   logic [7:0]  s_combo, s_max;
   logic [2:0]  s_mult;
   logic        s_jogando, s_novo;

   int total = 0;
   int bad   = 0;
   int n_novo = 0;
   int s_nnovo = 0;
   int base;

   typedef struct {
      logic [7:0] p;
      logic [7:0] e;
      int         sc;
      int         co;
      int         mx;
      int         mu;
      int         nv;
   } vetor_t;

   vetor_t tab[17];

   always #20 CLOCK_25 = ~CLOCK_25;

   contador_de_pontos dut (
      .CLOCK_25      (CLOCK_25),
      .rst_n         (rst_n),
      .ponto         (ponto),
      .erro          (erro),
      .inicio        (inicio),
      .fim_de_jogo   (fim_de_jogo),
      .score         (score),
      .combo         (combo),
      .max_combo     (max_combo),
      .multiplicador (multiplicador),
      .jogando       (jogando),
      .novo_ponto    (novo_ponto)
   );

   contador_de_pontos #(.SCORE_MAX(197)) u_sat (
      .CLOCK_25      (CLOCK_25),
      .rst_n         (rst_n),
      .ponto         (s_ponto),
      .erro          (s_erro),
      .inicio        (s_inicio),
      .fim_de_jogo   (s_fim),
      .score         (s_score),
      .combo         (s_combo),
      .max_combo     (s_max),
      .multiplicador (s_mult),
      .jogando       (s_jogando),
      .novo_ponto    (s_novo)
   );

   always @(posedge CLOCK_25) begin
      if (novo_ponto === 1'b1) n_novo <= n_novo + 1;
      if (s_novo === 1'b1) s_nnovo <= s_nnovo + 1;
   end

   task automatic chk(input string nome, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nome, act, exp);
      end
   endtask

   task automatic ciclo();
      @(posedge CLOCK_25);
      #1;
   endtask

   task automatic pulso(input logic [7:0] p, input logic [7:0] e);
      ponto = p;
      erro  = e;
      ciclo();
      ponto = '0;
      erro  = '0;
      repeat (3) ciclo();
   endtask

   task automatic sat_pulso(input logic [7:0] p);
      s_ponto = p;
      ciclo();
      s_ponto = '0;
      repeat (3) ciclo();
   endtask

   task automatic chk_all(input string nome, input int sc, input int co, input int mx,
                          input int mu);
      chk({nome, " score"}, int'(score), sc);
      chk({nome, " combo"}, int'(combo), co);
      chk({nome, " max_combo"}, int'(max_combo), mx);
      chk({nome, " mult"}, int'(multiplicador), mu);
   endtask

   initial begin
      tab[0]  = '{8'h01, 8'h00,   2,  2,  2, 1, 1};
      tab[1]  = '{8'h01, 8'h00,   3,  3,  3, 1, 1};
      tab[2]  = '{8'h01, 8'h00,   4,  4,  4, 1, 1};
      tab[3]  = '{8'h01, 8'h00,   5,  5,  5, 1, 1};
      tab[4]  = '{8'h7F, 8'h00,  12, 12, 12, 2, 1};
      tab[5]  = '{8'hFF, 8'h00,  28, 20, 20, 3, 1};
      tab[6]  = '{8'hFF, 8'h00,  52, 28, 28, 3, 1};
      tab[7]  = '{8'h03, 8'h00,  58, 30, 30, 4, 1};
      tab[8]  = '{8'h7F, 8'h00,  86, 37, 37, 4, 1};
      tab[9]  = '{8'h00, 8'h01,  86,  0, 37, 1, 0};
      tab[10] = '{8'hFF, 8'h00,  94,  8, 37, 1, 1};
      tab[11] = '{8'hFF, 8'h00, 102, 16, 37, 2, 1};
      tab[12] = '{8'hFF, 8'h00, 118, 24, 37, 3, 1};
      tab[13] = '{8'h7F, 8'h00, 139, 31, 37, 4, 1};
      tab[14] = '{8'h0F, 8'h00, 155, 35, 37, 4, 1};
      tab[15] = '{8'h06, 8'h08, 163,  0, 37, 1, 1};
      tab[16] = '{8'h18, 8'h10, 164,  0, 37, 1, 1};

      rst_n = 1'b0;
      ponto = '0; erro = '0; inicio = 1'b0; fim_de_jogo = 1'b0;
      s_ponto = '0; s_erro = '0; s_inicio = 1'b0; s_fim = 1'b0;
      repeat (2) ciclo();
      chk_all("reset", 0, 0, 0, 1);
      chk("reset jogando", int'(jogando), 0);
      chk("reset novo", int'(novo_ponto), 0);
      rst_n = 1'b1;
      ciclo();

      inicio = 1'b1;
      ciclo();
      inicio = 1'b0;
      chk("start jogando", int'(jogando), 1);

      // First hit with cycle-exact latency.
      ponto = 8'h01;
      ciclo();
      ponto = '0;
      chk("lat edge k score", int'(score), 0);
      ciclo();
      chk("lat edge k+1 score", int'(score), 1);
      chk("lat edge k+1 novo", int'(novo_ponto), 1);
      ciclo();
      chk("lat novo width", int'(novo_ponto), 0);
      ciclo();
      chk("lat novo count", n_novo, 1);

      for (int i = 0; i < 17; i++) begin
         base = n_novo;
         pulso(tab[i].p, tab[i].e);
         chk_all($sformatf("vec%0d", i), tab[i].sc, tab[i].co, tab[i].mx, tab[i].mu);
         chk($sformatf("vec%0d novo", i), n_novo - base, tab[i].nv);
      end

      // Long level on lane 4 counts once.
      base = n_novo;
      ponto = 8'h10;
      repeat (50) ciclo();
      ponto = '0;
      repeat (3) ciclo();
      chk_all("long", 165, 1, 37, 1);
      chk("long novo", n_novo - base, 1);

      // inicio and fim_de_jogo together: game ends.
      inicio = 1'b1;
      fim_de_jogo = 1'b1;
      ciclo();
      inicio = 1'b0;
      fim_de_jogo = 1'b0;
      chk("fim jogando", int'(jogando), 0);
      base = n_novo;
      pulso(8'hFF, 8'h00);
      chk_all("frozen", 165, 1, 37, 1);
      chk("frozen novo", n_novo - base, 0);
      chk("frozen jogando", int'(jogando), 0);

      // Restart, with a hit arriving in the transition cycle (dropped).
      base = n_novo;
      inicio = 1'b1;
      ponto = 8'h01;
      ciclo();
      inicio = 1'b0;
      ponto = '0;
      chk("restart jogando", int'(jogando), 1);
      chk_all("restart", 0, 0, 0, 1);
      repeat (3) ciclo();
      chk("drop score", int'(score), 0);
      chk("drop novo", n_novo - base, 0);
      pulso(8'h01, 8'h00);
      chk_all("after restart", 1, 1, 1, 1);

      // Asynchronous reset while an update is in flight.
      ponto = 8'hFF;
      ciclo();
      rst_n = 1'b0;
      #1;
      chk_all("async rst", 0, 0, 0, 1);
      chk("async rst jogando", int'(jogando), 0);
      chk("async rst novo", int'(novo_ponto), 0);
      ponto = '0;
      ciclo();
      rst_n = 1'b1;
      ciclo();
      base = n_novo;
      pulso(8'hFF, 8'h00);
      chk("idle score", int'(score), 0);
      chk("idle combo", int'(combo), 0);
      chk("idle jogando", int'(jogando), 0);
      chk("idle novo", n_novo - base, 0);

      // Saturation on the small-ceiling instance.
      s_inicio = 1'b1;
      ciclo();
      s_inicio = 1'b0;
      for (int i = 0; i < 8; i++) sat_pulso(8'hFF);
      chk("sat pre score", int'(s_score), 184);
      chk("sat pre mult", int'(s_mult), 4);
      base = s_nnovo;
      sat_pulso(8'hFF);
      chk("sat score", int'(s_score), 197);
      chk("sat novo", s_nnovo - base, 1);
      base = s_nnovo;
      sat_pulso(8'h01);
      chk("sat hold score", int'(s_score), 197);
      chk("sat hold novo", s_nnovo - base, 0);
      chk("sat combo", int'(s_combo), 73);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
